door_latch_ctrl: RTL and testbench
==================================

DOOR_LATCH_CTRL -- requirements
Module: door_latch_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_CYC, default 8: cycles the latch stays released awaiting door opening (legal 2..255).
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles the door may stay open before alarm (legal 2..255).
REQ-003 clk  input  1  clock, rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 unlock  input  1  one-cycle grant pulse from the combination-lock FSM (synchronous to clk).
REQ-006 door_closed_raw  input  1  door sensor, asynchronous, 1 = closed.
REQ-007 alarm_ack  input  1  operator acknowledge, synchronous level.
REQ-008 latch_release  output  1  drives solenoid, 1 = released.
REQ-009 alarm  output  1  alarm active.
REQ-010 door_state  output  2  current state encoding (LOCKED=0, RELEASED=1, OPENED=2, ALARM=3).
REQ-011 open_count  output  8  number of legitimate openings, saturating.

Function
REQ-012 door_closed_raw SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value door_closed_s (2-cycle latency).
REQ-013 FSM SHALL be Moore with states LOCKED, RELEASED, OPENED, ALARM; latch_release = (state==RELEASED), alarm = (state==ALARM), door_state = state, all decoded from the state register only.
REQ-014 LOCKED: door_closed_s=0 -> ALARM (forced entry, priority); else unlock=1 -> RELEASED, cnt<=0; else stay.
REQ-015 RELEASED: door_closed_s=0 -> OPENED, cnt<=0, open_count+1 (priority); else unlock=1 -> stay, cnt<=0 (window restart); else cnt==WINDOW_CYC-1 -> LOCKED; else cnt+1.
REQ-016 RELEASED SHALL therefore last exactly WINDOW_CYC cycles absent door opening or new unlock.
REQ-017 OPENED: door_closed_s=1 -> LOCKED; else cnt==HOLD_CYC-1 -> ALARM; else cnt+1; unlock ignored.
REQ-018 ALARM: door_closed_s=1 and alarm_ack=1 in same cycle -> LOCKED; otherwise stay; unlock ignored.
REQ-019 cnt SHALL be 8 bits unsigned; it SHALL never exceed max(WINDOW_CYC,HOLD_CYC)-1.
REQ-020 open_count SHALL saturate at 255 and never wrap.
REQ-021 Unreachable/illegal state encodings SHALL return to LOCKED on the next edge.

Reset
REQ-022 reset SHALL dominate all inputs; on the reset edge: state=LOCKED, cnt=0, open_count=0, both synchronizer flops=1 (closed).
REQ-023 Outputs after reset: latch_release=0, alarm=0, door_state=0, open_count=0.
REQ-024 reset asserted mid-RELEASED/OPENED/ALARM SHALL abort immediately to LOCKED with no alarm.
REQ-025 After reset, LOCKED SHALL not flag forced entry until door_closed_s reflects a real sensor low (synchronizer preload prevents false alarm).

Structure
REQ-026 Package door_pkg SHALL hold the door_state_t enum (2-bit explicit encodings) and default WINDOW_CYC/HOLD_CYC constants.
REQ-027 Synchronizer SHALL be a separate sub-module sync2 (parameterized reset value), instantiated once.
REQ-028 Implementation SHALL use one always_ff for state/cnt/open_count and one always_comb for next-state logic with defaults assigned first.

Verification (WINDOW_CYC=8, HOLD_CYC=16)
REQ-029 reset 2 cycles, door closed -> latch_release=0, alarm=0, door_state=0, open_count=0.
REQ-030 unlock pulse, door never opens -> latch_release=1 for exactly 8 cycles, then LOCKED, open_count=0.
REQ-031 unlock, raw goes low 3 cycles later, back high 5 cycles later -> RELEASED->OPENED 2 cycles after sync, open_count=1, LOCKED 2 cycles after raw rises, alarm never set.
REQ-032 unlock, door opened and held 20 cycles -> ALARM after 16 OPENED cycles; alarm_ack with door open -> stays ALARM; close door + ack -> LOCKED.
REQ-033 door_closed_raw low while LOCKED, no unlock -> ALARM 2 cycles after synchronizer captures it; latch_release stays 0.
REQ-034 unlock at cycle 0 and again at cycle 6 -> RELEASED lasts 14 cycles total; reset asserted in cycle 10 -> LOCKED next edge, outputs at reset values.

Source files
------------

// File: rtl/door_pkg.sv
// Shared types and defaults for the door latch controller.
package door_pkg;

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      RELEASED = 2'd1,
      OPENED   = 2'd2,
      ALARM    = 2'd3
   } door_state_t;

   localparam int unsigned DEF_WINDOW_CYC = 8;
   localparam int unsigned DEF_HOLD_CYC   = 16;

   localparam logic [1:0] ST_LOCKED   = LOCKED;
   localparam logic [1:0] ST_RELEASED = RELEASED;
   localparam logic [1:0] ST_OPENED   = OPENED;
   localparam logic [1:0] ST_ALARM    = ALARM;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with a configurable reset value.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/door_latch_ctrl.sv
// Door latch controller: releases the solenoid after an unlock grant, tracks the
// door opening and raises an alarm on forced entry or a door held open too long.
module door_latch_ctrl
   import door_pkg::*;
#(
   parameter int unsigned WINDOW_CYC = DEF_WINDOW_CYC,
   parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       unlock,
   input  logic       door_closed_raw,
   input  logic       alarm_ack,
   output logic       latch_release,
   output logic       alarm,
   output logic [1:0] door_state,
   output logic [7:0] open_count
);

   localparam logic [7:0] WIN_LAST  = 8'(WINDOW_CYC - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

   logic       door_closed_s;
   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] open_count_q, open_count_d;

   // Preloaded "closed" so a fresh reset never reports forced entry.
   sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync_door (
      .clk   (clk),
      .reset (reset),
      .d     (door_closed_raw),
      .q     (door_closed_s)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      open_count_d = open_count_q;
      case (state_q)
         ST_LOCKED: begin
            if (!door_closed_s) begin
               state_d = ST_ALARM;
            end else if (unlock) begin
               state_d = ST_RELEASED;
               cnt_d   = 8'd0;
            end
         end
         ST_RELEASED: begin
            if (!door_closed_s) begin
               state_d = ST_OPENED;
               cnt_d   = 8'd0;
               if (open_count_q != 8'hFF) open_count_d = open_count_q + 8'd1;
            end else if (unlock) begin
               cnt_d = 8'd0;
            end else if (cnt_q == WIN_LAST) begin
               state_d = ST_LOCKED;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_OPENED: begin
            if (door_closed_s) begin
               state_d = ST_LOCKED;
               cnt_d   = 8'd0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_ALARM;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_ALARM: begin
            if (door_closed_s && alarm_ack) state_d = ST_LOCKED;
         end
         default: begin
            state_d = ST_LOCKED;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_LOCKED;
         cnt_q        <= 8'd0;
         open_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         open_count_q <= open_count_d;
      end
   end

   assign latch_release = (state_q == ST_RELEASED);
   assign alarm         = (state_q == ST_ALARM);
   assign door_state    = state_q;
   assign open_count    = open_count_q;

endmodule

// File: tb/tb_door_latch_ctrl.sv
// Randomized and directed bench for door_latch_ctrl against a deadline-based model.
module tb_door_latch_ctrl;

   localparam int W = 8;
   localparam int H = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       unlock = 1'b0;
   logic       door_closed_raw = 1'b1;
   logic       alarm_ack = 1'b0;
   logic       latch_release;
   logic       alarm;
   logic [1:0] door_state;
   logic [7:0] open_count;

   int checks = 0;
   int errors = 0;

   door_latch_ctrl #(
      .WINDOW_CYC (W),
      .HOLD_CYC   (H)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .unlock          (unlock),
      .door_closed_raw (door_closed_raw),
      .alarm_ack       (alarm_ack),
      .latch_release   (latch_release),
      .alarm           (alarm),
      .door_state      (door_state),
      .open_count      (open_count)
   );

   always #5 clk = ~clk;

   // Model: mode 0..3 = locked/released/opened/alarm, timeouts as absolute edge numbers.
   int mode = 0;
   int deadline = 0;
   int edge_n = 0;
   int m_opens = 0;
   bit seen1 = 1'b1;
   bit seen2 = 1'b1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic model_step(input bit unl, input bit raw, input bit ack, input bit rst);
      bit closed;
      edge_n++;
      if (rst) begin
         mode = 0;
         m_opens = 0;
         seen1 = 1'b1;
         seen2 = 1'b1;
         return;
      end
      closed = seen2;
      seen2 = seen1;
      seen1 = raw;
      case (mode)
         0: if (!closed) mode = 3;
            else if (unl) begin mode = 1; deadline = edge_n + W; end
         1: if (!closed) begin
               mode = 2;
               deadline = edge_n + H;
               if (m_opens < 255) m_opens++;
            end else if (unl) deadline = edge_n + W;
            else if (edge_n == deadline) mode = 0;
         2: if (closed) mode = 0;
            else if (edge_n == deadline) mode = 3;
         default: if (closed && ack) mode = 0;
      endcase
   endtask

   task automatic step(input bit unl, input bit raw, input bit ack, input bit rst);
      unlock = unl;
      door_closed_raw = raw;
      alarm_ack = ack;
      reset = rst;
      @(posedge clk);
      model_step(unl, raw, ack, rst);
      #1;
      check_val("door_state", 32'(door_state), 32'(mode));
      check_val("latch_release", 32'(latch_release), 32'(mode == 1));
      check_val("alarm", 32'(alarm), 32'(mode == 3));
      check_val("open_count", 32'(open_count), 32'(m_opens));
   endtask

   int rel;
   int alarm_seen;
   bit r_door;

   initial begin
      // Reset, door closed.
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      check_val("reset_state", 32'(door_state), 32'd0);
      check_val("reset_count", 32'(open_count), 32'd0);

      // Unlock, door never opens: window length.
      step(1, 1, 0, 0);
      rel = int'(latch_release);
      repeat (12) begin
         step(0, 1, 0, 0);
         rel += int'(latch_release);
      end
      check_val("window_len", 32'(rel), 32'(W));

      // Legitimate opening, no alarm.
      alarm_seen = 0;
      step(1, 1, 0, 0);
      repeat (2) step(0, 1, 0, 0);
      repeat (5) begin step(0, 0, 0, 0); alarm_seen += int'(alarm); end
      repeat (6) begin step(0, 1, 0, 0); alarm_seen += int'(alarm); end
      check_val("legit_no_alarm", 32'(alarm_seen), 32'd0);
      check_val("legit_count", 32'(open_count), 32'd1);

      // Door held open -> alarm; ack with door open keeps alarm; close+ack clears.
      step(1, 1, 0, 0);
      repeat (20) step(0, 0, 0, 0);
      check_val("held_alarm", 32'(alarm), 32'd1);
      repeat (3) step(0, 0, 1, 0);
      check_val("ack_open_alarm", 32'(alarm), 32'd1);
      repeat (3) step(0, 1, 1, 0);
      check_val("cleared", 32'(door_state), 32'd0);

      // Forced entry while locked.
      repeat (4) step(0, 0, 0, 0);
      check_val("forced_alarm", 32'(alarm), 32'd1);
      repeat (3) step(0, 1, 1, 0);

      // Window restart: unlock at 0 and 6.
      rel = 0;
      for (int i = 0; i < 20; i++) begin
         step(i == 0 || i == 6, 1, 0, 0);
         rel += int'(latch_release);
      end
      check_val("restart_len", 32'(rel), 32'd14);

      // Reset mid-release aborts to locked.
      step(1, 1, 0, 0);
      repeat (4) step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      check_val("abort_state", 32'(door_state), 32'd0);
      check_val("abort_latch", 32'(latch_release), 32'd0);

      // Saturate the opening counter.
      for (int i = 0; i < 260; i++) begin
         step(1, 1, 0, 0);
         repeat (4) step(0, 0, 0, 0);
         repeat (4) step(0, 1, 0, 0);
      end
      check_val("saturated", 32'(open_count), 32'd255);

      // Random traffic.
      step(0, 1, 0, 1);
      r_door = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) == 0) r_door = ~r_door;
         step($urandom_range(5) == 0, r_door, $urandom_range(2) == 0,
              $urandom_range(199) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
